// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single-stage F/D pipeline buffer.
//
// The PC starts from the boot vector held at imem[0]. Words are fetched one
// per cycle. A word with opcode[5]=1 carries a second word (the immediate),
// so it is assembled over two fetch cycles. Taken branches, returns and
// interrupt vectors redirect the PC through jump_sel. A pending interrupt
// injects a marker slot into the F/D buffer ahead of the next instruction.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   pc_enable           PC/state advance enable from decode (0 = stall)
//   f_d_buffer_enable   F/D buffer load enable (0 = hold)
//   flush               load a bubble into the F/D buffer
//   jump_sel            00 sequential, 01 branch_addr, 10 mem_pc, 11 INT_VEC
//   branch_addr         branch/call target
//   mem_pc              return PC popped from the stack
//   interrupt           external interrupt request (pulse)
//   imem_addr           instruction memory address (combinational)
//   imem_data           instruction word for imem_addr, same cycle
//   opcode/src/dst/imm  F/D buffered instruction fields
//   pc_out              F/D buffered return PC (address after the instruction)
//   interrupt_out       F/D buffered interrupt-slot marker
//   fd_valid            F/D buffer holds an instruction or interrupt slot
module fetch_stage #(
    parameter int unsigned     W       = 16,
    parameter logic [W-1:0]    INT_VEC = W'(16'h0002)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_enable,
    input  logic         f_d_buffer_enable,
    input  logic         flush,
    input  logic [1:0]   jump_sel,
    input  logic [W-1:0] branch_addr,
    input  logic [W-1:0] mem_pc,
    input  logic         interrupt,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    output logic [5:0]   opcode,
    output logic [2:0]   src,
    output logic [2:0]   dst,
    output logic [W-1:0] imm,
    output logic [W-1:0] pc_out,
    output logic         interrupt_out,
    output logic         fd_valid
);

    localparam int unsigned OPC_W = 6;
    localparam int unsigned REG_W = 3;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        FETCH     = 2'd1,
        FETCH_IMM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      pc_q, pc_d;
    logic [OPC_W-1:0]  lat_opcode_q, lat_opcode_d;
    logic [REG_W-1:0]  lat_src_q, lat_src_d;
    logic [REG_W-1:0]  lat_dst_q, lat_dst_d;
    logic              pending_q, pending_d;
    logic              int_prev_q;

    // F/D load candidate; defaults to a bubble
    logic [OPC_W-1:0]  ld_opcode;
    logic [REG_W-1:0]  ld_src;
    logic [REG_W-1:0]  ld_dst;
    logic [W-1:0]      ld_imm;
    logic [W-1:0]      ld_pc;
    logic              ld_int;
    logic              ld_valid;

    logic              pend_clr;
    logic              int_rise;
    logic              jump_take;
    logic              advancing;
    logic [W-1:0]      pc_inc;
    logic [W-1:0]      jump_target;
    logic [OPC_W-1:0]  word_opcode;
    logic [REG_W-1:0]  word_src;
    logic [REG_W-1:0]  word_dst;

    // Instruction word fields of the currently presented memory word
    assign word_opcode = imem_data[15:10];
    assign word_src    = imem_data[9:7];
    assign word_dst    = imem_data[6:4];

    assign pc_inc    = pc_q + W'(1);
    assign jump_take = pc_enable && (jump_sel != 2'b00);
    assign advancing = pc_enable && (jump_sel == 2'b00);
    assign int_rise  = interrupt && !int_prev_q;

    // The boot vector always lives at address 0
    assign imem_addr = (state_q == BOOT) ? W'(0) : pc_q;

    // Redirect target selection
    always_comb begin
        jump_target = pc_inc;
        case (jump_sel)
            2'b01:   jump_target = branch_addr;
            2'b10:   jump_target = mem_pc;
            2'b11:   jump_target = INT_VEC;
            default: jump_target = pc_inc;
        endcase
    end

    // Sticky interrupt request; a new pulse wins over a same-cycle clear
    assign pending_d = (pending_q && !pend_clr) || int_rise;

    // Next state, PC, immediate latch and F/D load value
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lat_opcode_d = lat_opcode_q;
        lat_src_d    = lat_src_q;
        lat_dst_d    = lat_dst_q;
        pend_clr     = 1'b0;
        ld_opcode    = '0;
        ld_src       = '0;
        ld_dst       = '0;
        ld_imm       = '0;
        ld_pc        = '0;
        ld_int       = 1'b0;
        ld_valid     = 1'b0;

        case (state_q)
            BOOT: begin
                // Load the boot vector regardless of decode control
                pc_d    = imem_data;
                state_d = FETCH;
            end

            FETCH: begin
                if (jump_take) begin
                    pc_d = jump_target;
                end else if (advancing) begin
                    if (pending_q) begin
                        // Interrupt slot: resume at the un-fetched instruction
                        ld_opcode = '0;
                        ld_pc     = pc_q;
                        ld_int    = 1'b1;
                        ld_valid  = 1'b1;
                        pend_clr  = 1'b1;
                    end else if (word_opcode[OPC_W-1]) begin
                        // First half of a two-word instruction
                        lat_opcode_d = word_opcode;
                        lat_src_d    = word_src;
                        lat_dst_d    = word_dst;
                        pc_d         = pc_inc;
                        state_d      = FETCH_IMM;
                    end else begin
                        ld_opcode = word_opcode;
                        ld_src    = word_src;
                        ld_dst    = word_dst;
                        ld_pc     = pc_inc;
                        ld_valid  = 1'b1;
                        pc_d      = pc_inc;
                    end
                end
            end

            FETCH_IMM: begin
                if (jump_take) begin
                    // Abandon the partial instruction
                    pc_d         = jump_target;
                    state_d      = FETCH;
                    lat_opcode_d = '0;
                    lat_src_d    = '0;
                    lat_dst_d    = '0;
                end else if (advancing) begin
                    ld_opcode = lat_opcode_q;
                    ld_src    = lat_src_q;
                    ld_dst    = lat_dst_q;
                    ld_imm    = imem_data;
                    ld_pc     = pc_inc;
                    ld_valid  = 1'b1;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else if (pc_enable || (state_q == BOOT)) begin
            state_q <= state_d;
        end
    end

    // PC, immediate latch and interrupt tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            lat_opcode_q <= '0;
            lat_src_q    <= '0;
            lat_dst_q    <= '0;
            pending_q    <= 1'b0;
            int_prev_q   <= 1'b0;
        end else begin
            if (pc_enable || (state_q == BOOT)) begin
                pc_q         <= pc_d;
                lat_opcode_q <= lat_opcode_d;
                lat_src_q    <= lat_src_d;
                lat_dst_q    <= lat_dst_d;
            end
            pending_q  <= pending_d;
            int_prev_q <= interrupt;
        end
    end

    // F/D buffer: flush beats hold beats load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode        <= '0;
            src           <= '0;
            dst           <= '0;
            imm           <= '0;
            pc_out        <= '0;
            interrupt_out <= 1'b0;
            fd_valid      <= 1'b0;
        end else if (flush) begin
            opcode        <= '0;
            src           <= '0;
            dst           <= '0;
            imm           <= '0;
            pc_out        <= '0;
            interrupt_out <= 1'b0;
            fd_valid      <= 1'b0;
        end else if (f_d_buffer_enable) begin
            opcode        <= ld_opcode;
            src           <= ld_src;
            dst           <= ld_dst;
            imm           <= ld_imm;
            pc_out        <= ld_pc;
            interrupt_out <= ld_int;
            fd_valid      <= ld_valid;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// A behavioural instruction memory is driven combinationally from imem_addr.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pc_enable;
    logic        f_d_buffer_enable;
    logic        flush;
    logic [1:0]  jump_sel;
    logic [15:0] branch_addr;
    logic [15:0] mem_pc;
    logic        interrupt;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [5:0]  opcode;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    logic [15:0] pc_out;
    logic        interrupt_out;
    logic        fd_valid;

    logic [15:0] imem [0:65535];

    int n_checks;
    int n_fail;

    fetch_stage #(.W(16), .INT_VEC(16'h0002)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_enable         (pc_enable),
        .f_d_buffer_enable (f_d_buffer_enable),
        .flush             (flush),
        .jump_sel          (jump_sel),
        .branch_addr       (branch_addr),
        .mem_pc            (mem_pc),
        .interrupt         (interrupt),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .opcode            (opcode),
        .src               (src),
        .dst               (dst),
        .imm               (imm),
        .pc_out            (pc_out),
        .interrupt_out     (interrupt_out),
        .fd_valid          (fd_valid)
    );

    assign imem_data = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [15:0] exp);
        chk({tag, ".imem_addr"}, imem_addr, exp);
    endtask

    task automatic chk_fd(input string tag, input logic [5:0] op, input logic [2:0] s,
                          input logic [2:0] d, input logic [15:0] im, input logic [15:0] pco,
                          input logic io, input logic v);
        chk({tag, ".opcode"},        16'(opcode),        16'(op));
        chk({tag, ".src"},           16'(src),           16'(s));
        chk({tag, ".dst"},           16'(dst),           16'(d));
        chk({tag, ".imm"},           imm,                im);
        chk({tag, ".pc_out"},        pc_out,             pco);
        chk({tag, ".interrupt_out"}, 16'(interrupt_out), 16'(io));
        chk({tag, ".fd_valid"},      16'(fd_valid),      16'(v));
    endtask

    task automatic bubble(input string tag);
        chk_fd(tag, 6'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic jump(input logic [1:0] sel, input logic [15:0] tgt);
        jump_sel    = sel;
        branch_addr = tgt;
        step();
        jump_sel    = 2'b00;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        pc_enable         = 1'b1;
        f_d_buffer_enable = 1'b1;
        flush             = 1'b0;
        jump_sel          = 2'b00;
        branch_addr       = 16'h0000;
        mem_pc            = 16'h0000;
        interrupt         = 1'b0;
        for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;

        // One-word fetch after boot
        imem[16'h0000] = 16'h0010;
        imem[16'h0010] = 16'h0420;
        step();
        chk_addr("rst", 16'h0000);
        bubble("rst");
        rst = 1'b0;
        chk_addr("boot", 16'h0000);
        step();
        chk_addr("boot_edge", 16'h0010);
        bubble("boot_edge");
        step();
        chk_addr("one_word", 16'h0011);
        chk_fd("one_word", 6'h01, 3'd0, 3'd2, 16'h0000, 16'h0011, 1'b0, 1'b1);

        // Two-word fetch
        rst = 1'b1;
        imem[16'h0010] = 16'h8000;
        imem[16'h0011] = 16'hBEEF;
        imem[16'h0012] = 16'h0420;
        imem[16'h0040] = 16'h0FB0;
        imem[16'h0002] = 16'h0FB0;
        imem[16'hFFFF] = 16'h0420;
        do_reset();
        step();
        chk_addr("b_boot", 16'h0010);
        step();
        chk_addr("two_first", 16'h0011);
        bubble("two_first");
        step();
        chk_addr("two_second", 16'h0012);
        chk_fd("two_second", 6'h20, 3'd0, 3'd0, 16'hBEEF, 16'h0012, 1'b0, 1'b1);

        // Branch out of a partial two-word fetch
        jump(2'b01, 16'h0010);
        chk_addr("jmp10", 16'h0010);
        bubble("jmp10");
        step();
        chk_addr("imm_wait", 16'h0011);
        jump(2'b01, 16'h0040);
        chk_addr("abandon", 16'h0040);
        bubble("abandon");
        step();
        chk_addr("after_abandon", 16'h0041);
        chk_fd("after_abandon", 6'h03, 3'd7, 3'd3, 16'h0000, 16'h0041, 1'b0, 1'b1);

        // Interrupt arriving during FETCH_IMM
        jump(2'b01, 16'h0010);
        step();
        chk_addr("int_imm_wait", 16'h0011);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        chk_addr("int_imm_done", 16'h0012);
        chk_fd("int_imm_done", 6'h20, 3'd0, 3'd0, 16'hBEEF, 16'h0012, 1'b0, 1'b1);
        step();
        chk_addr("int_slot", 16'h0012);
        chk_fd("int_slot", 6'h00, 3'd0, 3'd0, 16'h0000, 16'h0012, 1'b1, 1'b1);
        step();
        chk_addr("int_resume", 16'h0013);
        chk_fd("int_resume", 6'h01, 3'd0, 3'd2, 16'h0000, 16'h0013, 1'b0, 1'b1);
        jump(2'b11, 16'h0000);
        chk_addr("int_vec", 16'h0002);
        bubble("int_vec");

        // Stall and flush
        step();
        chk_addr("pre_stall", 16'h0003);
        chk_fd("pre_stall", 6'h03, 3'd7, 3'd3, 16'h0000, 16'h0003, 1'b0, 1'b1);
        pc_enable         = 1'b0;
        f_d_buffer_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_addr("stall", 16'h0003);
            chk_fd("stall", 6'h03, 3'd7, 3'd3, 16'h0000, 16'h0003, 1'b0, 1'b1);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_addr("flush", 16'h0003);
        bubble("flush");
        pc_enable         = 1'b1;
        f_d_buffer_enable = 1'b1;

        // PC wrap at the top of the address space
        jump(2'b01, 16'hFFFF);
        chk_addr("to_ffff", 16'hFFFF);
        step();
        chk_addr("wrap", 16'h0000);
        chk_fd("wrap", 6'h01, 3'd0, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a two-word fetch
        jump(2'b01, 16'h0010);
        step();
        chk_addr("mid_two", 16'h0011);
        #2;
        rst = 1'b1;
        #1;
        chk_addr("async_rst", 16'h0000);
        bubble("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk_addr("reboot", 16'h0010);
        bubble("reboot");
        step();
        chk_addr("reboot_first", 16'h0011);
        bubble("reboot_first");
        step();
        chk_fd("reboot_second", 6'h20, 3'd0, 3'd0, 16'hBEEF, 16'h0012, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter W, 16, data/address/PC width.
REQ-002 Parameter INT_VEC, 16'h0002, PC target loaded when jump_sel=11.
REQ-003 Ports clk (in, 1, single clock) and rst (in, 1): one clock; reset is asynchronous and active-high.
REQ-004 pc_enable  in  1  PC/state update enable from decode (0 = stall).
REQ-005 f_d_buffer_enable  in  1  F/D buffer load enable (0 = hold).
REQ-006 flush  in  1  load a bubble into the F/D buffer.
REQ-007 jump_sel  in  2  00 sequential, 01 branch_addr, 10 mem_pc, 11 INT_VEC.
REQ-008 branch_addr  in  W  branch/call target.
REQ-009 mem_pc  in  W  return PC popped from stack (RET/RTI).
REQ-010 interrupt  in  1  external interrupt request, ≥1-cycle pulse.
REQ-011 imem_addr  out  W  instruction memory address (combinational).
REQ-012 imem_data  in  W  instruction word, valid in the same cycle as imem_addr.
REQ-013 opcode  out  6, src  out  3, dst  out  3: F/D buffered fields.
REQ-014 imm  out  W: F/D buffered immediate, 0 for one-word instructions.
REQ-015 pc_out  out  W: F/D buffered return PC (address after the full instruction).
REQ-016 interrupt_out  out  1: F/D buffered interrupt-slot marker.
REQ-017 fd_valid  out  1: F/D buffer holds a real instruction or interrupt slot.

Function
REQ-018 Word format: opcode=[15:10], src=[9:7], dst=[6:4]; opcode[5]=1 marks a two-word instruction whose second word is imm.
REQ-019 States: BOOT, FETCH, FETCH_IMM; a bubble is opcode/src/dst/imm/pc_out=0, interrupt_out=0, fd_valid=0.
REQ-020 BOOT: imem_addr=0; on the next edge PC<=imem_data, state->FETCH, F/D loads a bubble; pc_enable and jump_sel are ignored.
REQ-021 FETCH/FETCH_IMM: imem_addr=PC.
REQ-022 FETCH, one-word word, advancing: F/D loads the fields, imm=0, pc_out=PC+1, fd_valid=1; PC<=PC+1.
REQ-023 FETCH, two-word word, advancing: opcode/src/dst are held in an internal latch; F/D loads a bubble; PC<=PC+1; state->FETCH_IMM.
REQ-024 FETCH_IMM, advancing: F/D loads the latched fields, imm=imem_data, pc_out=PC+1, fd_valid=1; PC<=PC+1; state->FETCH.
REQ-025 "Advancing" means pc_enable=1 and jump_sel=00; PC arithmetic is mod 2^W, so 16'hFFFF+1=0.
REQ-026 pc_enable=0: PC, state and the internal latch hold; F/D follows REQ-029/REQ-030 independently.
REQ-027 pc_enable=1 with jump_sel≠00: PC<=selected target, state->FETCH (abandons a partial two-word fetch), F/D loads a bubble; this takes priority over REQ-022..024.
REQ-028 interrupt: rising pulse sets a sticky pending bit; a pulse in the same cycle as its clear leaves pending set.
REQ-029 Pending set, state FETCH, pc_enable=1, jump_sel=00: F/D loads opcode=0, interrupt_out=1, pc_out=PC (un-fetched instruction), fd_valid=1; PC holds; pending clears; no injection in BOOT or FETCH_IMM.
REQ-030 F/D priority: flush=1 -> bubble (overrides all loads); else f_d_buffer_enable=0 -> hold; else load per REQ-020..029.
REQ-031 flush has no effect on PC/state; jump redirection is driven only by jump_sel.

Reset
REQ-032 rst=1 asynchronously forces state=BOOT, PC=0, internal latch=0, pending=0, and all F/D outputs to 0 (including fd_valid and interrupt_out), with imem_addr=0.
REQ-033 Reset asserted mid-two-word fetch discards the partial instruction; after deassertion, fetch restarts from BOOT.

Verification
REQ-034 imem[0]=16'h0010, imem[0x10]=16'h0420 (one-word) -> after release: cycle 1 PC=0x10; cycle 2 opcode=01, src=0, dst=2, pc_out=0x11, fd_valid=1.
REQ-035 imem[0x10]=16'h8000, imem[0x11]=16'hBEEF -> first edge gives a bubble; second edge gives opcode=0x20, imm=0xBEEF, pc_out=0x12; PC=0x12.
REQ-036 In FETCH_IMM at PC=0x11, pc_enable=1, jump_sel=01, branch_addr=0x40 -> PC=0x40, state FETCH, F/D bubble, latch discarded.
REQ-037 Interrupt pulse arriving at PC=0x11 while in FETCH_IMM -> the immediate completes first; next edge gives interrupt_out=1, pc_out=0x12, PC held at 0x12; later jump_sel=11 -> PC=0x0002.
REQ-038 pc_enable=0 and f_d_buffer_enable=0 for 3 cycles -> PC and outputs unchanged; flush=1 during the stall -> F/D becomes a bubble and PC is unchanged.
REQ-039 PC=16'hFFFF fetching a one-word word -> pc_out=0, PC=0.
